// File: rtl/debug_uart_pkg.sv
// Shared types and helpers for the UART sample dump path.
package debug_uart_pkg;

   typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT_RD, SEND, FIN} dump_state_t;

   localparam int UART_FRAME_BITS = 10;

   function automatic int nbytes(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, with a valid/ready byte handshake.
module uart_tx_byte
   import debug_uart_pkg::*;
#(
   parameter int CLKS_PER_BAUD = 217
) (
   input  logic       clk_25mhz,
   input  logic       rst_in,
   input  logic [7:0] byte_in,
   input  logic       byte_valid_in,
   output logic       byte_ready_out,
   output logic       uart_tx
);

   localparam int BW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
   localparam logic [BW-1:0] RELOAD = BW'(CLKS_PER_BAUD - 1);
   localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;     // bits still to go after the one on the line: d0..d7, stop

   always_ff @(posedge clk_25mhz) begin
      if (!rst_in) begin
         uart_tx        <= 1'b1;
         byte_ready_out <= 1'b1;
         baud_cnt       <= '0;
         bit_cnt        <= '0;
         shreg          <= '0;
      end else if (byte_ready_out) begin
         if (byte_valid_in) begin
            uart_tx        <= 1'b0;
            shreg          <= {1'b1, byte_in};
            baud_cnt       <= RELOAD;
            bit_cnt        <= '0;
            byte_ready_out <= 1'b0;
         end
      end else if (baud_cnt != '0) begin
         baud_cnt <= baud_cnt - 1'b1;
      end else if (bit_cnt == LAST_BIT) begin
         // stop bit finished; line is already high
         byte_ready_out <= 1'b1;
      end else begin
         uart_tx  <= shreg[0];
         shreg    <= {1'b0, shreg[8:1]};
         bit_cnt  <= bit_cnt + 1'b1;
         baud_cnt <= RELOAD;
      end
   end

endmodule

// File: rtl/uart_sample_dumper.sv
// Streams a window of the sample buffer out over UART: sync byte, 16-bit count,
// then each sample MSB byte first.
module uart_sample_dumper
   import debug_uart_pkg::*;
#(
   parameter int          SAMPLE_W      = 16,
   parameter int          DEPTH         = 4096,
   parameter int          CLKS_PER_BAUD = 217,
   parameter int          READ_LATENCY  = 2,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   localparam int         INDEX_W       = $clog2(DEPTH)
) (
   input  logic                clk_25mhz,
   input  logic                rst_in,
   input  logic                start_in,
   input  logic [INDEX_W-1:0]  start_index_in,
   input  logic [INDEX_W:0]    count_in,
   input  logic [SAMPLE_W-1:0] debug_data_in,
   output logic [INDEX_W-1:0]  debug_index_out,
   output logic                uart_tx,
   output logic                busy_out,
   output logic                done_out
);

   localparam int NB  = nbytes(SAMPLE_W);
   localparam int SW  = NB * 8;
   localparam int BCW = $clog2(NB + 1);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);

   dump_state_t           state;
   logic [INDEX_W-1:0]    idx;
   logic [INDEX_W:0]      left;
   logic [1:0]            hdr_cnt;
   logic [BCW-1:0]        byte_cnt;
   logic [SW-1:0]         sh;
   logic [READ_LATENCY:0] vld_pipe;
   logic [7:0]            byte_data;
   logic                  byte_valid;
   logic                  byte_ready;

   logic [31:0]   cnt_ext;
   logic [SW-1:0] data_pad;
   logic [SW-1:0] sh_next;
   logic          accept;

   assign cnt_ext  = 32'(left);
   assign data_pad = SW'(debug_data_in);
   assign sh_next  = sh << 8;
   assign accept   = byte_valid && byte_ready;

   always_ff @(posedge clk_25mhz) begin
      if (!rst_in) begin
         state           <= IDLE;
         idx             <= '0;
         left            <= '0;
         hdr_cnt         <= '0;
         byte_cnt        <= '0;
         sh              <= '0;
         vld_pipe        <= '0;
         byte_data       <= '0;
         byte_valid      <= 1'b0;
         busy_out        <= 1'b0;
         done_out        <= 1'b0;
         debug_index_out <= '0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: if (start_in) begin
               idx        <= start_index_in;
               left       <= count_in;
               hdr_cnt    <= '0;
               byte_data  <= SYNC_BYTE;
               byte_valid <= 1'b1;
               busy_out   <= 1'b1;
               state      <= HDR;
            end
            HDR: if (accept) begin
               hdr_cnt <= hdr_cnt + 1'b1;
               case (hdr_cnt)
                  2'd0:    byte_data <= cnt_ext[15:8];
                  2'd1:    byte_data <= cnt_ext[7:0];
                  default: begin
                     byte_valid <= 1'b0;
                     state      <= (left == '0) ? FIN : FETCH;
                  end
               endcase
            end
            FETCH: begin
               debug_index_out <= idx;
               vld_pipe        <= (READ_LATENCY + 1)'(1);
               state           <= WAIT_RD;
            end
            WAIT_RD: if (vld_pipe[READ_LATENCY]) begin
               sh         <= data_pad;
               byte_data  <= data_pad[SW-1 -: 8];
               byte_valid <= 1'b1;
               byte_cnt   <= '0;
               idx        <= idx + 1'b1;   // INDEX_W wide, so wraps modulo DEPTH
               left       <= left - 1'b1;
               vld_pipe   <= '0;
               state      <= SEND;
            end else begin
               vld_pipe <= vld_pipe << 1;
            end
            SEND: if (accept) begin
               if (byte_cnt == LAST_BYTE) begin
                  byte_valid <= 1'b0;
                  state      <= (left == '0) ? FIN : FETCH;
               end else begin
                  byte_cnt  <= byte_cnt + 1'b1;
                  sh        <= sh_next;
                  byte_data <= sh_next[SW-1 -: 8];
               end
            end
            // the serializer is ready again only once the last stop bit is out
            FIN: if (byte_ready) begin
               done_out <= 1'b1;
               busy_out <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   uart_tx_byte #(.CLKS_PER_BAUD(CLKS_PER_BAUD)) u_tx (
      .clk_25mhz      (clk_25mhz),
      .rst_in         (rst_in),
      .byte_in        (byte_data),
      .byte_valid_in  (byte_valid),
      .byte_ready_out (byte_ready),
      .uart_tx        (uart_tx)
   );

endmodule
